// File: rtl/cp0_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cp0_pkg
// Description : Shared constants and helpers for the CP0 exception controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cp0_pkg;

  localparam logic [4:0] c_reg_count   = 5'd9;
  localparam logic [4:0] c_reg_compare = 5'd11;
  localparam logic [4:0] c_reg_status  = 5'd12;
  localparam logic [4:0] c_reg_cause   = 5'd13;
  localparam logic [4:0] c_reg_epc     = 5'd14;

  localparam logic [4:0] c_exc_syscall = 5'b01000;
  localparam logic [4:0] c_exc_break   = 5'b01001;
  localparam logic [4:0] c_exc_teq     = 5'b01101;
  localparam logic [4:0] c_exc_int     = 5'b00000;

  localparam int c_st_ie  = 0;
  localparam int c_st_sys = 1;
  localparam int c_st_brk = 2;
  localparam int c_st_teq = 3;
  localparam int c_st_int = 4;

  localparam int c_ca_code_lo = 2;
  localparam int c_ca_irq_lo  = 8;
  localparam int c_ca_timer   = 15;
  localparam int c_ca_ovf     = 31;

  function automatic logic exc_known(input logic [4:0] code);
    return (code == c_exc_syscall) || (code == c_exc_break) || (code == c_exc_teq);
  endfunction

  // STATUS enable bit guarding each synchronous exception class
  function automatic int exc_en_bit(input logic [4:0] code);
    case (code)
      c_exc_syscall: return c_st_sys;
      c_exc_break:   return c_st_brk;
      default:       return c_st_teq;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_timer.sv
`default_nettype none
// ============================================================================
// Module      : cp0_timer
// Description : Free-running COUNT with COMPARE match and sticky pending flag.
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_count,
  input  logic        wr_compare,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        pending
);

  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count   <= '0;
      r_compare <= '0;
      r_pending <= 1'b0;
    end else begin
      r_count <= wr_count ? wdata : r_count + 32'd1;
      // Rewriting COMPARE acknowledges the timer interrupt
      if (wr_compare) begin
        r_compare <= wdata;
        r_pending <= 1'b0;
      end else if ((r_count == r_compare) && (r_compare != 32'd0)) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign count   = r_count;
  assign compare = r_compare;
  assign pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/cp0_exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cp0_exc_ctrl
// Description : CP0 exception/interrupt controller with nested status frames.
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter int          MASK_W     = 5,
  parameter int          NEST_DEPTH = 3,
  parameter int          NUM_IRQ    = 4,
  parameter logic [31:0] VECTOR     = 32'h00400004,
  parameter logic [31:0] STATUS_RST = 32'h1f
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                ena,
  input  logic                                mfc0,
  input  logic                                mtc0,
  input  logic [31:0]                         pc,
  input  logic [4:0]                          cp0_addr,
  input  logic [31:0]                         wdata,
  input  logic                                exception,
  input  logic                                eret,
  input  logic [4:0]                          cause,
  input  logic [NUM_IRQ-1:0]                  irq,
  output logic [31:0]                         rdata,
  output logic [31:0]                         status,
  output logic [31:0]                         exc_addr,
  output logic                                redirect,
  output logic [$clog2(NEST_DEPTH+1)-1:0]     nest_depth
);

  localparam int                 DEPTH_W     = $clog2(NEST_DEPTH + 1);
  localparam logic [DEPTH_W-1:0] c_depth_max = DEPTH_W'(NEST_DEPTH);

  logic [NUM_IRQ-1:0] r_irq_s1;
  logic [NUM_IRQ-1:0] r_irq_s2;
  logic [31:0]        r_status;
  logic [31:0]        r_epc;
  logic [4:0]         r_code;
  logic               r_ovf;
  logic [DEPTH_W-1:0] r_depth;
  logic [31:0]        r_exc_addr;
  logic               r_redirect;

  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_pending;
  logic [31:0] w_cause;
  logic        w_can_nest;
  logic        w_exc_act;
  logic        w_exc_en;
  logic        w_irq_req;
  logic        w_do_mtc0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq_s1 <= '0;
      r_irq_s2 <= '0;
    end else begin
      r_irq_s1 <= irq;
      r_irq_s2 <= r_irq_s1;
    end
  end

  assign w_can_nest = (r_depth < c_depth_max);
  assign w_exc_act  = exception && exc_known(cause);
  assign w_exc_en   = r_status[c_st_ie] && r_status[exc_en_bit(cause)];
  assign w_irq_req  = r_status[c_st_ie] && r_status[c_st_int] &&
                      ((|r_irq_s2) || w_pending) && w_can_nest;
  // mtc0 only lands when nothing of higher priority claims the commit
  assign w_do_mtc0  = ena && mtc0 && !eret && !w_exc_act && !w_irq_req;

  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .wr_count   (w_do_mtc0 && (cp0_addr == c_reg_count)),
    .wr_compare (w_do_mtc0 && (cp0_addr == c_reg_compare)),
    .wdata      (wdata),
    .count      (w_count),
    .compare    (w_compare),
    .pending    (w_pending)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_status   <= STATUS_RST;
      r_epc      <= '0;
      r_code     <= '0;
      r_ovf      <= 1'b0;
      r_depth    <= '0;
      r_exc_addr <= '0;
      r_redirect <= 1'b0;
    end else begin
      r_redirect <= 1'b0;
      if (ena) begin
        if (eret) begin
          if (r_depth != '0) begin
            r_status <= r_status >> MASK_W;
            r_depth  <= r_depth - 1'b1;
          end
          r_exc_addr <= r_epc;
          r_redirect <= 1'b1;
        end else if (w_exc_act) begin
          if (w_exc_en && w_can_nest) begin
            r_status   <= r_status << MASK_W;
            r_depth    <= r_depth + 1'b1;
            r_epc      <= pc;
            r_code     <= cause;
            r_exc_addr <= VECTOR;
          end else begin
            // Suppressed exception: skip the faulting instruction
            r_exc_addr <= pc + 32'd4;
            if (w_exc_en) r_ovf <= 1'b1;
          end
          r_redirect <= 1'b1;
        end else if (w_irq_req) begin
          r_status   <= r_status << MASK_W;
          r_depth    <= r_depth + 1'b1;
          r_epc      <= pc;
          r_code     <= c_exc_int;
          r_exc_addr <= VECTOR;
          r_redirect <= 1'b1;
        end else if (mtc0) begin
          case (cp0_addr)
            c_reg_status: r_status <= wdata;
            c_reg_cause:  r_ovf    <= wdata[c_ca_ovf];
            c_reg_epc:    r_epc    <= wdata;
            default:      ;
          endcase
        end
      end
    end
  end

  always_comb begin
    w_cause                             = '0;
    w_cause[c_ca_code_lo +: 5]          = r_code;
    w_cause[c_ca_irq_lo +: NUM_IRQ]     = r_irq_s2;
    w_cause[c_ca_timer]                 = w_pending;
    w_cause[c_ca_ovf]                   = r_ovf;
  end

  always_comb begin
    rdata = '0;
    if (mfc0) begin
      case (cp0_addr)
        c_reg_count:   rdata = w_count;
        c_reg_compare: rdata = w_compare;
        c_reg_status:  rdata = r_status;
        c_reg_cause:   rdata = w_cause;
        c_reg_epc:     rdata = r_epc;
        default:       rdata = '0;
      endcase
    end
  end

  assign status     = r_status;
  assign exc_addr   = r_exc_addr;
  assign redirect   = r_redirect;
  assign nest_depth = r_depth;

endmodule
`default_nettype wire

// File: tb/tb_cp0_exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cp0_exc_ctrl
// Description : Scoreboard bench for cp0_exc_ctrl against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_exc_ctrl;

  localparam int          NIRQ = 4;
  localparam logic [31:0] VEC  = 32'h00400004;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ena = 1'b0, mfc0 = 1'b0, mtc0 = 1'b0, exception = 1'b0, eret = 1'b0;
  logic [31:0]       pc = '0, wdata = '0;
  logic [4:0]        cp0_addr = '0, cause = '0;
  logic [NIRQ-1:0]   irq = '0;
  logic [31:0]       rdata, status, exc_addr;
  logic              redirect;
  logic [1:0]        nest_depth;

  cp0_exc_ctrl dut (
    .clk(clk), .rst(rst), .ena(ena), .mfc0(mfc0), .mtc0(mtc0), .pc(pc),
    .cp0_addr(cp0_addr), .wdata(wdata), .exception(exception), .eret(eret),
    .cause(cause), .irq(irq), .rdata(rdata), .status(status),
    .exc_addr(exc_addr), .redirect(redirect), .nest_depth(nest_depth)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] st; int depth; } exp_t;
  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: architectural registers and cycle-level timer/irq view
  logic [31:0]     m_status, m_epc, m_count, m_compare;
  logic [4:0]      m_code;
  bit              m_ovf, m_pend;
  int              m_depth;
  logic [NIRQ-1:0] m_seen_prev, m_seen;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_status = 32'h1f; m_epc = 0; m_count = 0; m_compare = 0;
    m_code = 0; m_ovf = 0; m_pend = 0; m_depth = 0;
    m_seen_prev = 0; m_seen = 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd9:  return m_count;
      5'd11: return m_compare;
      5'd12: return m_status;
      5'd13: return (32'(m_ovf) << 31) | (32'(m_pend) << 15) | (32'(m_seen) << 8) | (32'(m_code) << 2);
      5'd14: return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  // One clock: drive at negedge, check reads, advance model, end at next negedge
  task automatic step(input bit e, er, ex, mt, mf, input logic [4:0] cd, a,
                      input logic [31:0] p, wd, input logic [NIRQ-1:0] iv);
    bit rd = 0, wr_cnt = 0, wr_cmp = 0, en, known;
    logic [31:0] ra = 0;
    int idx;
    ena = e; eret = er; exception = ex; mtc0 = mt; mfc0 = mf;
    cause = cd; cp0_addr = a; pc = p; wdata = wd; irq = iv;
    #1;
    check("rdata", rdata, mf ? model_read(a) : 32'h0);
    check("nest_depth", 32'(nest_depth), 32'(m_depth));
    known = (cd == 5'd8) || (cd == 5'd9) || (cd == 5'd13);
    idx   = (cd == 5'd8) ? 1 : (cd == 5'd9) ? 2 : 3;
    if (e) begin
      if (er) begin
        rd = 1; ra = m_epc;
        if (m_depth > 0) begin m_status = m_status / 32; m_depth--; end
      end else if (ex && known) begin
        en = m_status[0] && m_status[idx];
        rd = 1;
        if (en && m_depth < 3) begin
          m_epc = p; m_code = cd; m_status = m_status * 32; m_depth++; ra = VEC;
        end else begin
          ra = p + 32'd4;
          if (en) m_ovf = 1;
        end
      end else if (m_status[0] && m_status[4] && (m_seen != 0 || m_pend) && m_depth < 3) begin
        rd = 1; ra = VEC; m_epc = p; m_code = 0; m_status = m_status * 32; m_depth++;
      end else if (mt) begin
        case (a)
          5'd9:  wr_cnt = 1;
          5'd11: wr_cmp = 1;
          5'd12: m_status = wd;
          5'd13: m_ovf = wd[31];
          5'd14: m_epc = wd;
          default: ;
        endcase
      end
    end
    if (wr_cmp) m_pend = 0;
    else if (m_count == m_compare && m_compare != 0) m_pend = 1;
    if (wr_cmp) m_compare = wd;
    m_count = wr_cnt ? wd : m_count + 32'd1;
    m_seen = m_seen_prev; m_seen_prev = iv;
    if (rd) q.push_back('{ra, m_status, m_depth});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, irq);
  endtask

  task automatic do_reset();
    rst = 1; ena = 0; mtc0 = 0; mfc0 = 0; exception = 0; eret = 0; irq = 0;
    q.delete();
    repeat (2) @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  task automatic peek(input string name, input logic [4:0] a, input logic [31:0] exp);
    mfc0 = 1; cp0_addr = a; #1;
    check(name, rdata, exp);
    mfc0 = 0;
  endtask

  // Monitor: every redirect pulse must match the oldest queued expectation
  initial begin
    exp_t x;
    forever begin
      @(posedge clk); #1;
      if (!rst && redirect) begin
        if (q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_redirect: got exc_addr %h expected no redirect", exc_addr);
        end else begin
          x = q.pop_front();
          check("exc_addr", exc_addr, x.addr);
          check("status", status, x.st);
          check("depth_at_redirect", 32'(nest_depth), 32'(x.depth));
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [4:0]  a, cd;
    logic [NIRQ-1:0] iv;
    model_reset();
    @(negedge clk);
    do_reset();

    // Reset state
    peek("reset_status", 5'd12, 32'h1f);
    peek("reset_cause", 5'd13, 32'h0);
    peek("reset_epc", 5'd14, 32'h0);
    check("reset_redirect", 32'(redirect), 32'h0);
    check("reset_depth", 32'(nest_depth), 32'h0);

    // Taken syscall
    step(1, 0, 1, 0, 0, 5'd8, 0, 32'h00400100, 0, 0);
    peek("sys_epc", 5'd14, 32'h00400100);
    peek("sys_cause", 5'd13, 32'h20);
    peek("sys_status", 5'd12, 32'h3e0);
    check("sys_depth", 32'(nest_depth), 32'h1);

    // Disabled syscall skips to pc+4
    do_reset();
    step(1, 0, 0, 1, 0, 0, 5'd12, 0, 32'h1d, 0);
    step(1, 0, 1, 0, 0, 5'd8, 0, 32'h100, 0, 0);
    peek("dis_epc", 5'd14, 32'h0);

    // Nested breaks to full depth, overflow, then unwind
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1, 0, 0, 5'd9, 0, 32'h1000 + 32'(16 * i), 0, 0);
      if (i < 3) step(1, 0, 0, 1, 0, 0, 5'd12, 0, m_status | 32'h1f, 0);
    end
    peek("ovf_cause", 5'd13, 32'h8000_0024);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    peek("unwound_status", 5'd12, 32'h1f);
    step(1, 0, 0, 1, 0, 0, 5'd13, 0, 32'h0, 0);
    peek("ovf_clear", 5'd13, 32'h24);

    // External interrupt through the synchroniser
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 32'h200, 0, 4'b0100);
    peek("irq_cause", 5'd13, 32'h400);
    peek("irq_epc", 5'd14, 32'h200);
    idle(2);
    irq = 0;
    idle(3);

    // Timer compare interrupt, acknowledge, and a dropped mtc0
    do_reset();
    step(1, 0, 0, 1, 0, 0, 5'd11, 0, 32'd10, 0);
    idle(12);
    peek("timer_pend", 5'd13, 32'h8000);
    step(1, 0, 0, 0, 0, 0, 0, 32'h300, 0, 0);
    peek("timer_epc", 5'd14, 32'h300);
    step(1, 0, 0, 1, 0, 0, 5'd11, 0, 32'd5000, 0);
    peek("timer_ack", 5'd13, 32'h0);
    step(1, 0, 1, 1, 0, 5'd13, 5'd14, 32'h400, 32'hdead, 0);
    peek("mtc0_dropped", 5'd14, 32'h300);

    // Randomised traffic against the model
    do_reset();
    iv = 0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 40) == 0) iv = NIRQ'($urandom);
      cd = ($urandom_range(0, 7) == 0) ? 5'd5 :
           ($urandom_range(0, 2) == 0) ? 5'd8 : ($urandom_range(0, 1) == 0) ? 5'd9 : 5'd13;
      case ($urandom_range(0, 6))
        0: a = 5'd9;  1: a = 5'd11; 2: a = 5'd12; 3: a = 5'd13;
        4: a = 5'd14; 5: a = 5'd0;  default: a = 5'($urandom);
      endcase
      case (a)
        5'd11:   v = m_count + 32'($urandom_range(1, 15));
        5'd12:   v = ($urandom_range(0, 4) == 0) ? $urandom : (32'h1f | ($urandom & 32'h3e0));
        default: v = $urandom;
      endcase
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, cd,
           ($urandom_range(0, 1) == 0) ? a : 5'($urandom_range(0, 15)),
           $urandom & 32'hffff_fffc, v, iv);
    end
    idle(3);
    check("queue_drained", 32'(q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
